hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding tracker: follows in-flight register and flag writers
// through the pipeline and derives stall, forwarding selects and busy mask.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 8,
  parameter int REG_AW       = 3,
  parameter int PIPE_DEPTH   = 4,
  parameter int LOAD_STAGE   = 2,
  parameter int FLAG_STAGE   = 1,
  parameter int FLUSH_STAGES = 2,
  parameter int SEL_W        = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                issue_valid,
  input  logic                issue_dest_en,
  input  logic [REG_AW-1:0]   issue_dest,
  input  logic                issue_is_load,
  input  logic                issue_sets_flags,
  input  logic                src1_en,
  input  logic                src2_en,
  input  logic [REG_AW-1:0]   src1,
  input  logic [REG_AW-1:0]   src2,
  input  logic                uses_flags,
  input  logic                flush,
  output logic                stall,
  output logic [SEL_W-1:0]    fwd_sel1,
  output logic [SEL_W-1:0]    fwd_sel2,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [15:0]         stall_count
);

  logic [PIPE_DEPTH-1:0]             vld_q, vld_d;
  logic [PIPE_DEPTH-1:0]             den_q, den_d;
  logic [PIPE_DEPTH-1:0]             ld_q, ld_d;
  logic [PIPE_DEPTH-1:0]             sf_q, sf_d;
  logic [PIPE_DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [15:0]                       cnt_q, cnt_d;

  logic lu1, lu2, flag_hz;

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    lu1      = 1'b0;
    lu2      = 1'b0;
    flag_hz  = 1'b0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      if (src1_en && vld_q[k] && den_q[k] && dst_q[k] == src1) begin
        fwd_sel1 = SEL_W'(k + 1);
        lu1      = ld_q[k] && (k < LOAD_STAGE);
      end
      if (src2_en && vld_q[k] && den_q[k] && dst_q[k] == src2) begin
        fwd_sel2 = SEL_W'(k + 1);
        lu2      = ld_q[k] && (k < LOAD_STAGE);
      end
      if (uses_flags && vld_q[k] && sf_q[k] && (k < FLAG_STAGE))
        flag_hz = 1'b1;
    end
    stall = issue_valid && (lu1 || lu2 || flag_hz);
  end

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < PIPE_DEPTH; k++)
      if (vld_q[k] && den_q[k])
        busy_mask[dst_q[k]] = 1'b1;
  end

  always_comb begin
    den_d    = {den_q[PIPE_DEPTH-2:0], issue_dest_en};
    ld_d     = {ld_q[PIPE_DEPTH-2:0], issue_is_load};
    sf_d     = {sf_q[PIPE_DEPTH-2:0], issue_sets_flags};
    dst_d    = {dst_q[PIPE_DEPTH-2:0], issue_dest};
    vld_d    = '0;
    vld_d[0] = issue_valid && !stall && !flush;
    // Flush kills the youngest in-flight writers as they advance.
    for (int k = 1; k < PIPE_DEPTH; k++)
      vld_d[k] = vld_q[k-1] && !(flush && (k - 1) < FLUSH_STAGES);
    cnt_d = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      den_q <= '0;
      ld_q  <= '0;
      sf_q  <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      den_q <= den_d;
      ld_q  <= ld_d;
      sf_q  <= sf_d;
      dst_q <= dst_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a list-of-instructions model
// predicts each cycle's outputs; a monitor compares them against the DUT.
module tb_hazard_scoreboard;

  logic       CLK = 1'b0;
  logic       RST;
  logic       issue_valid, issue_dest_en, issue_is_load, issue_sets_flags;
  logic [2:0] issue_dest, src1, src2;
  logic       src1_en, src2_en, uses_flags, flush;
  logic       stall;
  logic [2:0] fwd_sel1, fwd_sel2;
  logic [7:0] busy_mask;
  logic [15:0] stall_count;

  hazard_scoreboard dut (
    .CLK(CLK), .RST(RST),
    .issue_valid(issue_valid), .issue_dest_en(issue_dest_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load),
    .issue_sets_flags(issue_sets_flags),
    .src1_en(src1_en), .src2_en(src2_en), .src1(src1), .src2(src2),
    .uses_flags(uses_flags), .flush(flush),
    .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, iv, den, ld, sf;
    logic [2:0] dst;
    logic       s1e, s2e;
    logic [2:0] s1, s2;
    logic       uf, fl;
  } stim_t;

  typedef struct {
    logic        st;
    logic [2:0]  f1, f2;
    logic [7:0]  bm;
    logic [15:0] sc;
  } exp_t;

  typedef struct {
    logic       den, ld, sf;
    logic [2:0] dst;
    int         age;
  } instr_t;

  exp_t   expq[$];
  instr_t infl[$];
  int     mcnt;
  stim_t  cur;
  logic   cur_stall;
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     done    = 0;

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t wr(input logic [2:0] d, input logic ld,
                               input logic sf);
    stim_t s = nop();
    s.iv = 1; s.den = 1; s.dst = d; s.ld = ld; s.sf = sf;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 299) == 0);
    s.iv  = ($urandom_range(0, 3) != 0);
    s.den = $urandom_range(0, 1);
    s.dst = 3'($urandom_range(0, 7));
    s.ld  = ($urandom_range(0, 2) == 0);
    s.sf  = $urandom_range(0, 1);
    s.s1e = $urandom_range(0, 1);
    s.s2e = $urandom_range(0, 1);
    s.s1  = 3'($urandom_range(0, 7));
    s.s2  = 3'($urandom_range(0, 7));
    s.uf  = ($urandom_range(0, 2) == 0);
    s.fl  = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  // Youngest in-flight writer of s, if any.
  function automatic void find(input logic en, input logic [2:0] s,
                               output logic [2:0] sel, output logic lu);
    int best = 1000;
    sel = 0;
    lu  = 0;
    if (!en) return;
    foreach (infl[i])
      if (infl[i].den && infl[i].dst == s && infl[i].age < best) begin
        best = infl[i].age;
        sel  = 3'(best + 1);
        lu   = infl[i].ld && best < 2;
      end
  endfunction

  function automatic void advance();
    instr_t nq[$];
    instr_t e;
    if (cur.rst) begin
      infl.delete();
      mcnt = 0;
      return;
    end
    if (cur_stall && mcnt < 65535) mcnt++;
    foreach (infl[i]) begin
      if (cur.fl && infl[i].age < 2) continue;
      e = infl[i];
      e.age++;
      if (e.age < 4) nq.push_back(e);
    end
    if (cur.iv && !cur_stall && !cur.fl) begin
      e.den = cur.den; e.ld = cur.ld; e.sf = cur.sf;
      e.dst = cur.dst; e.age = 0;
      nq.push_back(e);
    end
    infl = nq;
  endfunction

  function automatic void predict();
    exp_t x;
    logic lu1, lu2, fh;
    find(cur.s1e, cur.s1, x.f1, lu1);
    find(cur.s2e, cur.s2, x.f2, lu2);
    fh   = 0;
    x.bm = 0;
    foreach (infl[i]) begin
      if (cur.uf && infl[i].sf && infl[i].age < 1) fh = 1;
      if (infl[i].den) x.bm[infl[i].dst] = 1;
    end
    x.st = cur.iv && (lu1 || lu2 || fh);
    x.sc = 16'(mcnt);
    cur_stall = x.st;
    expq.push_back(x);
  endfunction

  task automatic drive(input stim_t s);
    @(posedge CLK);
    advance();
    #1;
    cur = s;
    RST = s.rst;
    issue_valid = s.iv; issue_dest_en = s.den; issue_dest = s.dst;
    issue_is_load = s.ld; issue_sets_flags = s.sf;
    src1_en = s.s1e; src2_en = s.s2e; src1 = s.s1; src2 = s.s2;
    uses_flags = s.uf; flush = s.fl;
    if (s.rst) begin
      infl.delete();
      mcnt = 0;
    end
    predict();
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t x;
    while (!done) begin
      @(negedge CLK);
      while (expq.size() > 0) begin
        x = expq.pop_front();
        chk("stall", int'(stall), int'(x.st));
        chk("fwd_sel1", int'(fwd_sel1), int'(x.f1));
        chk("fwd_sel2", int'(fwd_sel2), int'(x.f2));
        chk("busy_mask", int'(busy_mask), int'(x.bm));
        chk("stall_count", int'(stall_count), int'(x.sc));
      end
    end
  end

  initial begin : driver
    stim_t s;
    cur = nop();
    cur.rst = 1;
    cur_stall = 0;
    mcnt = 0;
    RST = 1;
    {issue_valid, issue_dest_en, issue_is_load, issue_sets_flags} = '0;
    {issue_dest, src1, src2, src1_en, src2_en, uses_flags, flush} = '0;
    for (int i = 0; i < 4; i++) begin
      s = rnd();
      s.rst = 1;
      drive(s);
    end
    drive(nop());
    drive(nop());
    // back-to-back and one-bubble ALU forwarding
    drive(wr(3, 0, 0));
    s = nop(); s.iv = 1; s.s1e = 1; s.s1 = 3;
    drive(s);
    drive(wr(3, 0, 0));
    drive(nop());
    drive(s);
    repeat (4) drive(nop());
    // load-use: consumer held while stalled
    drive(wr(5, 1, 0));
    s = nop(); s.iv = 1; s.s2e = 1; s.s2 = 5;
    repeat (3) drive(s);
    repeat (4) drive(nop());
    // youngest writer wins
    drive(wr(2, 0, 0));
    drive(wr(2, 0, 0));
    s = nop(); s.iv = 1; s.s1e = 1; s.s1 = 2;
    drive(s);
    repeat (4) drive(nop());
    // flag hazard
    drive(wr(4, 0, 1));
    s = nop(); s.iv = 1; s.uf = 1;
    repeat (2) drive(s);
    repeat (4) drive(nop());
    // flush with a same-cycle issue
    drive(wr(1, 0, 0));
    drive(wr(2, 0, 0));
    drive(wr(3, 0, 0));
    s = wr(4, 0, 0); s.fl = 1;
    drive(s);
    repeat (5) drive(nop());
    // randomized traffic
    for (int i = 0; i < 2000; i++) drive(rnd());
    drive(nop());
    @(posedge CLK);
    repeat (2) @(negedge CLK);
    done = 1;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
